// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider.
//   state_t   : FSM encoding (IDLE -> CALC -> DONE -> IDLE)
//   DEFAULT_W : default operand/result width
package divider_pkg;

  localparam int DEFAULT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_borrow.sv
// Combinational N-bit subtractor with borrow, used for the restoring
// division trial step.
//   a, b       : unsigned operands
//   diff       : a - b modulo 2^N
//   borrow_out : 1 when b > a
module sub_borrow #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  // Extending both operands by one zero bit turns the carry-out of the
  // wide subtraction into the borrow.
  assign {borrow_out, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
//   clk, rst          : clock and asynchronous active-high reset
//   start             : begin a division (only honoured in IDLE)
//   dividend, divisor : unsigned operands, captured on the accepting edge
//   busy              : high in CALC and DONE
//   done              : one-cycle pulse in DONE
//   quotient,
//   remainder,
//   div_by_zero       : results, updated only on entry to DONE
import divider_pkg::*;

module seq_divider #(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg;
  // dvd_reg shifts the dividend out at the top while quotient bits
  // shift in at the bottom; after W steps it holds the quotient.
  logic [W-1:0]   dvd_reg;
  logic [W-1:0]   dvs_reg;
  logic [W-1:0]   rem_reg;
  logic [W-1:0]   quo_out_reg;
  logic [W-1:0]   rem_out_reg;
  logic           dbz_reg;

  logic           accept;
  logic           last_iter;
  logic [W:0]     rem_shift;
  logic [W:0]     trial_diff;
  logic           trial_borrow;
  logic [W-1:0]   rem_next;
  logic [W-1:0]   quo_next;
  logic           diff_msb_unused;

  assign accept    = (state_reg == IDLE) && start;
  assign last_iter = (state_reg == CALC) && (cnt_reg == CW'(W - 1));

  // Trial step: shift in the next dividend bit and try to subtract.
  assign rem_shift = {rem_reg, dvd_reg[W-1]};

  sub_borrow #(.N(W + 1)) u_sub (
    .a          (rem_shift),
    .b          ({1'b0, dvs_reg}),
    .diff       (trial_diff),
    .borrow_out (trial_borrow)
  );

  // The kept value is always below the divisor, so bit W is zero and
  // the partial remainder can be stored in W bits.
  assign rem_next        = trial_borrow ? rem_shift[W-1:0] : trial_diff[W-1:0];
  assign quo_next        = {dvd_reg[W-2:0], ~trial_borrow};
  assign diff_msb_unused = trial_diff[W];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      quo_out_reg <= '0;
      rem_out_reg <= '0;
      dbz_reg     <= 1'b0;
    end else if (accept) begin
      dvd_reg <= dividend;
      dvs_reg <= divisor;
      rem_reg <= '0;
      cnt_reg <= '0;
      if (divisor == '0) begin
        // Skip CALC entirely; results are defined directly.
        quo_out_reg <= '1;
        rem_out_reg <= dividend;
        dbz_reg     <= 1'b1;
      end
    end else if (state_reg == CALC) begin
      dvd_reg <= quo_next;
      rem_reg <= rem_next;
      cnt_reg <= cnt_reg + CW'(1);
      if (last_iter) begin
        quo_out_reg <= quo_next;
        rem_out_reg <= rem_next;
        dbz_reg     <= 1'b0;
      end
    end
  end

  assign quotient    = quo_out_reg;
  assign remainder   = rem_out_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           acc;
  } exp_t;

  exp_t sb[$];

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Result monitor: pops the scoreboard on each done pulse and checks
  // that outputs hold between pulses.
  logic         prev_done = 1'b0;
  logic [W-1:0] hold_q = '0;
  logic [W-1:0] hold_r = '0;
  logic         hold_z = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_q = '0;
        hold_r = '0;
        hold_z = 1'b0;
      end else if (done) begin
        check("single_pulse", 32'(prev_done), 0);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("quotient", 32'(quotient), 32'(e.q));
          check("remainder", 32'(remainder), 32'(e.r));
          check("div_by_zero", 32'(div_by_zero), 32'(e.z));
          check("latency", 32'(cycle - e.acc + 1), e.z ? 1 : W + 1);
          if (!e.z) begin
            check("identity", 32'(int'(quotient) * int'(e.b) + int'(remainder)), 32'(e.a));
            check("rem_lt_div", 32'(remainder < e.b), 1);
          end
          $display("div %0d/%0d -> q=%0d r=%0d dbz=%0d latency=%0d",
                   e.a, e.b, quotient, remainder, div_by_zero, cycle - e.acc + 1);
        end
        hold_q = quotient;
        hold_r = remainder;
        hold_z = div_by_zero;
      end else begin
        check("hold_q", 32'(quotient), 32'(hold_q));
        check("hold_r", 32'(remainder), 32'(hold_r));
        check("hold_z", 32'(div_by_zero), 32'(hold_z));
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  // Drive one division (caller is away from the rising edge) and push
  // the expected result computed from the operands.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.a   = a;
    e.b   = b;
    e.z   = (b == '0);
    e.q   = (b == '0) ? {W{1'b1}} : a / b;
    e.r   = (b == '0) ? a : a % b;
    e.acc = cycle + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int guard;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_q", 32'(quotient), 0);
    check("rst_r", 32'(remainder), 0);
    check("rst_z", 32'(div_by_zero), 0);

    // Start driven together with reset release: accepted on the first edge
    #2 rst = 1'b0;
    do_div(4'd13, 4'd3);
    do_div(4'd15, 4'd1);
    do_div(4'd2, 4'd9);
    do_div(4'd7, 4'd0);
    do_div(4'd6, 4'd4);

    // A start pulse two cycles into a division must be ignored
    do_div(4'd12, 4'd5);
    @(negedge clk);
    dividend = 4'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset in the second CALC cycle aborts the division
    wait_idle();
    @(negedge clk);
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_q", 32'(quotient), 0);
    check("abort_r", 32'(remainder), 0);
    check("abort_z", 32'(div_by_zero), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 0);
      check("abort_idle", 32'(busy), 0);
    end
    do_div(4'd14, 4'd3);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(4'(a), 4'(b));
      end
    end

    // Drain the scoreboard
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 32'(sb.size()), 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
